// File: rtl/fir_pkg.sv
// Shared sizing, state encoding and Gray helper for the distributed-arithmetic LUT loader.
package fir_pkg;

    localparam int unsigned NUM_TAPS      = 64;
    localparam int unsigned TAPS_PER_BANK = 8;
    localparam int unsigned NUM_BANKS     = 8;
    localparam int unsigned LUT_DEPTH     = 2048;
    localparam int unsigned COEF_W        = 16;
    localparam int unsigned LUT_W         = 20;

    localparam int unsigned TAP_W    = $clog2(NUM_TAPS);
    localparam int unsigned BIT_W    = $clog2(TAPS_PER_BANK);
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS);
    localparam int unsigned PAT_W    = $clog2(LUT_DEPTH / NUM_BANKS);
    localparam int unsigned ADDR_W   = BANK_W + PAT_W;
    localparam int unsigned STRIDE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [PAT_W-1:0] gray(input logic [PAT_W-1:0] n);
        return n ^ (n >> 1);
    endfunction

endpackage

// File: rtl/da_gray_step.sv
// Gray step decoder: for step n>0, the bank bit that toggles (trailing-zero count of n)
// and whether that bit turns on (add) or off (subtract).
module da_gray_step
    import fir_pkg::*;
(
    input  logic [PAT_W-1:0] step_i,
    output logic [BIT_W-1:0] bit_idx_c_o,
    output logic             add_c_o
);

    logic             found;
    logic [PAT_W:0]   step_ext;

    always_comb begin
        bit_idx_c_o = '0;
        found       = 1'b0;
        step_ext    = {1'b0, step_i};
        for (int i = 0; i < int'(PAT_W); i++) begin
            if (!found && step_i[i]) begin
                bit_idx_c_o = BIT_W'(i);
                found       = 1'b1;
            end
        end
        // Gray bit b of n equals n[b]^n[b+1]; n[b] is 1 here, so it turns on iff n[b+1] is 0.
        add_c_o = ~step_ext[(BIT_W+1)'(bit_idx_c_o) + (BIT_W+1)'(1)];
    end

endmodule

// File: rtl/da_lut_loader.sv
// Loads 64 tap coefficients and streams the 2048-entry DA LUT in per-bank Gray order.
// Optional feature macro: DA_LUT_CHKSUM_EN adds a 32-bit running checksum output.
module da_lut_loader
    import fir_pkg::*;
#(
    parameter int unsigned STRIDE = 1
) (
    input  logic              clk_fast,
    input  logic              resetn,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_valid,
    output logic              coef_ready,
    output logic [LUT_W-1:0]  CIN,
    output logic [ADDR_W-1:0] CADDR,
    output logic              CLOAD,
    output logic              busy,
    output logic              done
`ifdef DA_LUT_CHKSUM_EN
    ,
    output logic [31:0]       chksum
`endif
);

    state_e              state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [ADDR_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [STRIDE_W-1:0] str_q, str_d;
    logic [LUT_W-1:0]    acc_q, acc_d, acc_nxt;
    logic [LUT_W-1:0]    cin_q, cin_d;
    logic [ADDR_W-1:0]   caddr_q, caddr_d;
    logic                cload_q, cload_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                rf_we, xfer, last_win, last_entry;
    logic [BIT_W-1:0]    step_bit;
    logic                step_add;
    logic [LUT_W-1:0]    tap_ext;
    logic [COEF_W-1:0]   rf_q [NUM_TAPS];
`ifdef DA_LUT_CHKSUM_EN
    logic [31:0]         chk_q, chk_d;
`endif

    da_gray_step u_gray_step (
        .step_i      (idx_nxt[PAT_W-1:0]),
        .bit_idx_c_o (step_bit),
        .add_c_o     (step_add)
    );

    assign xfer       = coef_valid & ready_q;
    assign last_win   = (str_q == STRIDE_W'(STRIDE - 1));
    assign last_entry = (idx_q == ADDR_W'(LUT_DEPTH - 1));
    assign idx_nxt    = idx_q + ADDR_W'(1);
    assign tap_ext    = LUT_W'($signed(rf_q[{idx_nxt[ADDR_W-1:PAT_W], step_bit}]));

    // Next LUT value: restart at zero on each bank boundary, otherwise one Gray add/sub.
    always_comb begin
        if (idx_nxt[PAT_W-1:0] == '0) begin
            acc_nxt = '0;
        end else if (step_add) begin
            acc_nxt = acc_q + tap_ext;
        end else begin
            acc_nxt = acc_q - tap_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        idx_d   = idx_q;
        str_d   = str_q;
        acc_d   = acc_q;
        cin_d   = cin_q;
        caddr_d = caddr_q;
        cload_d = cload_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        rf_we   = 1'b0;
`ifdef DA_LUT_CHKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = LOAD;
                ready_d = 1'b1;
            end
            LOAD: begin
                if (xfer) begin
                    rf_we  = 1'b1;
                    tap_d  = tap_q + TAP_W'(1);
                    busy_d = 1'b1;
                    if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        // Entry 0 of bank 0 is always zero, so it can go out on this edge.
                        state_d = GEN;
                        ready_d = 1'b0;
                        idx_d   = '0;
                        str_d   = '0;
                        acc_d   = '0;
                        cin_d   = '0;
                        caddr_d = '0;
                        cload_d = 1'b1;
`ifdef DA_LUT_CHKSUM_EN
                        chk_d   = '0;
`endif
                    end
                end
            end
            GEN: begin
                if (last_win) begin
                    str_d = '0;
`ifdef DA_LUT_CHKSUM_EN
                    chk_d = chk_q + 32'($signed(cin_q));
`endif
                    if (last_entry) begin
                        state_d = DONE;
                        acc_d   = '0;
                        cin_d   = '0;
                        caddr_d = '0;
                        cload_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_nxt;
                        acc_d   = acc_nxt;
                        cin_d   = acc_nxt;
                        caddr_d = {idx_nxt[ADDR_W-1:PAT_W], gray(idx_nxt[PAT_W-1:0])};
                    end
                end else begin
                    str_d = str_q + STRIDE_W'(1);
                end
            end
            DONE: begin
                state_d = LOAD;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_fast or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            tap_q   <= '0;
            idx_q   <= '0;
            str_q   <= '0;
            acc_q   <= '0;
            cin_q   <= '0;
            caddr_q <= '0;
            cload_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef DA_LUT_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            idx_q   <= idx_d;
            str_q   <= str_d;
            acc_q   <= acc_d;
            cin_q   <= cin_d;
            caddr_q <= caddr_d;
            cload_q <= cload_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef DA_LUT_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Coefficient register file, written only by LOAD-state handshakes.
    always_ff @(posedge clk_fast or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[tap_q] <= coef_data;
        end
    end

    assign coef_ready = ready_q;
    assign CIN        = cin_q;
    assign CADDR      = caddr_q;
    assign CLOAD      = cload_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef DA_LUT_CHKSUM_EN
    assign chksum     = chk_q;
`endif

endmodule

// File: tb/tb_da_lut_loader.sv
// Scoreboard bench for da_lut_loader: expected LUT entries are computed from the
// direct bit-sum definition when coefficients are driven and popped as CLOAD windows appear.
module tb_da_lut_loader;
    import fir_pkg::*;

    localparam int unsigned S = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LUT_W-1:0]  val;
    } lut_ent_t;

    logic              clk_fast = 1'b0;
    logic              resetn;
    logic [COEF_W-1:0] coef_data;
    logic              coef_valid;
    logic              coef_ready;
    logic [LUT_W-1:0]  CIN;
    logic [ADDR_W-1:0] CADDR;
    logic              CLOAD;
    logic              busy;
    logic              done;
`ifdef DA_LUT_CHKSUM_EN
    logic [31:0]       chksum;
`endif

    lut_ent_t           sb_q[$];
    logic signed [15:0] coef_m [NUM_TAPS];
    logic [31:0]        exp_sum;
    int                 n_cmp;
    int                 n_err;

    da_lut_loader #(.STRIDE(S)) dut (
        .clk_fast   (clk_fast),
        .resetn     (resetn),
        .coef_data  (coef_data),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .CIN        (CIN),
        .CADDR      (CADDR),
        .CLOAD      (CLOAD),
        .busy       (busy),
        .done       (done)
`ifdef DA_LUT_CHKSUM_EN
        ,
        .chksum     (chksum)
`endif
    );

    always #5 clk_fast = ~clk_fast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected stream in emission order; values from the direct subset-sum definition.
    task automatic push_expected();
        lut_ent_t   e;
        logic [7:0] p;
        int         v;
        exp_sum = '0;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 256; n++) begin
                p = 8'(n ^ (n >> 1));
                v = 0;
                for (int b = 0; b < 8; b++) begin
                    if (p[b]) v += int'(coef_m[k*8+b]);
                end
                e.addr = {3'(k), p};
                e.val  = 20'(v);
                sb_q.push_back(e);
                exp_sum += 32'(v);
            end
        end
    endtask

    task automatic load_coefs();
        int t;
        push_expected();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                coef_valid = 1'b0;
                @(negedge clk_fast);
            end
            coef_valid = 1'b1;
            coef_data  = coef_m[i];
            t = 0;
            while (coef_ready !== 1'b1 && t < 50) begin
                @(negedge clk_fast);
                t++;
            end
            check("ready_wait", 32'(t < 50), 32'd1);
            @(negedge clk_fast);
            if (i == 0) check("busy_first", 32'(busy), 32'd1);
        end
        coef_valid = 1'b0;
        coef_data  = '0;
    endtask

    task automatic check_gen(input int n_ent, input bit hold_valid);
        lut_ent_t cur;
        cur = '0;
        if (hold_valid) begin
            coef_valid = 1'b1;
            coef_data  = 16'h7FFF;
        end
        for (int c = 0; c < n_ent * int'(S); c++) begin
            if (c > 0) @(negedge clk_fast);
            if (c % int'(S) == 0) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) cur = sb_q.pop_front();
            end
            check("cload", 32'(CLOAD), 32'd1);
            check("caddr", 32'(CADDR), 32'(cur.addr));
            check("cin", 32'(CIN), 32'(cur.val));
            check("ready_gen", 32'(coef_ready), 32'd0);
        end
        coef_valid = 1'b0;
        coef_data  = '0;
        if (n_ent == 2048) begin
            @(negedge clk_fast);
            check("cload_end", 32'(CLOAD), 32'd0);
            check("done", 32'(done), 32'd1);
            check("cin_done", 32'(CIN), 32'd0);
            check("caddr_done", 32'(CADDR), 32'd0);
            check("busy_done", 32'(busy), 32'd0);
`ifdef DA_LUT_CHKSUM_EN
            check("chksum", chksum, exp_sum);
`endif
            @(negedge clk_fast);
            check("done_pulse", 32'(done), 32'd0);
            check("ready_reload", 32'(coef_ready), 32'd1);
            check("busy_reload", 32'(busy), 32'd0);
            check("cload_idle", 32'(CLOAD), 32'd0);
`ifdef DA_LUT_CHKSUM_EN
            check("chksum_hold", chksum, exp_sum);
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cload"}, 32'(CLOAD), 32'd0);
        check({tag, "_cin"}, 32'(CIN), 32'd0);
        check({tag, "_caddr"}, 32'(CADDR), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(coef_ready), 32'd0);
`ifdef DA_LUT_CHKSUM_EN
        check({tag, "_chksum"}, chksum, 32'd0);
`endif
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        repeat (2) @(negedge clk_fast);
        check_all_zero("rst");
        resetn = 1'b1;
        @(negedge clk_fast);
        check("ready_load", 32'(coef_ready), 32'd1);
        check("busy_pre", 32'(busy), 32'd0);

        // All ones, with coef_valid held high through GEN to show it is ignored.
        for (int i = 0; i < 64; i++) coef_m[i] = 16'sd1;
        load_coefs();
        check_gen(2048, 1'b1);

        for (int i = 0; i < 64; i++) coef_m[i] = (i / 8 == 2) ? -16'sd16384 : 16'sd0;
        load_coefs();
        check_gen(2048, 1'b0);

        for (int i = 0; i < 64; i++) coef_m[i] = 16'sd32767;
        load_coefs();
        check_gen(2048, 1'b0);

        // Abort mid-GEN with an asynchronous reset, then reload and regenerate from scratch.
        for (int i = 0; i < 64; i++) coef_m[i] = 16'($urandom);
        load_coefs();
        check_gen(1001, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        sb_q.delete();
        @(negedge clk_fast);
        resetn = 1'b1;
        for (int i = 0; i < 64; i++) coef_m[i] = 16'($urandom);
        load_coefs();
        check_gen(2048, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
